// File: rtl/dp_sequencer.sv
// dp_sequencer: multi-cycle controller for the 4-register shift/merge datapath.
// Accepts one command at a time and sequences rsel/w/Rw/Rr/loadA/aluop/loadN,
// reporting completion with done, err (illegal op) and flag (datapath N).
// Optional feature macro: DP_SEQ_REPEAT_EN (repeat ALU ops up to rpt+1 times).
module dp_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [1:0] rd,
  input  logic [1:0] ra,
  input  logic [1:0] rb,
  input  logic [3:0] rpt,
  input  logic       N,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic       flag,
  output logic       rsel,
  output logic       w,
  output logic       loadA,
  output logic       loadN,
  output logic [1:0] Rw,
  output logic [1:0] Rr,
  output logic [1:0] aluop
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRIN, S_FETCHA, S_EXEC, S_CHK, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_SHL   = 3'b001,
    OP_SHL1  = 3'b010,
    OP_MERGE = 3'b011,
    OP_SUBHI = 3'b100
  } op_e;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [1:0] rd_q, rd_d;
  logic [1:0] ra_q, ra_d;
  logic [1:0] rb_q, rb_d;
  logic       err_q, err_d;
  logic       flag_q, flag_d;
  logic       first_iter;

  // Registered control outputs
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       err_o_q, err_o_d;
  logic       flag_o_q, flag_o_d;
  logic       rsel_q, rsel_d;
  logic       w_q, w_d;
  logic       loadA_q, loadA_d;
  logic       loadN_q, loadN_d;
  logic [1:0] Rw_q, Rw_d;
  logic [1:0] Rr_q, Rr_d;
  logic [1:0] aluop_q, aluop_d;

  logic       shl_d;

`ifdef DP_SEQ_REPEAT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  assign first_iter = first_d;
`else
  logic       rpt_unused;
  assign rpt_unused = ^rpt;
  assign first_iter = 1'b1;
`endif

  // Next-state logic and command capture
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    err_d   = err_q;
    flag_d  = flag_q;
`ifdef DP_SEQ_REPEAT_EN
    cnt_d   = cnt_q;
    first_d = first_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          rd_d   = rd;
          ra_d   = ra;
          rb_d   = rb;
          err_d  = 1'b0;
          flag_d = 1'b0;
`ifdef DP_SEQ_REPEAT_EN
          cnt_d   = rpt;
          first_d = 1'b1;
`endif
          case (op)
            OP_LOAD:            state_d = S_WRIN;
            OP_SHL, OP_SHL1:    state_d = S_EXEC;
            OP_MERGE, OP_SUBHI: state_d = S_FETCHA;
            default: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_WRIN:   state_d = S_DONE;
      S_FETCHA: state_d = S_EXEC;
      S_EXEC:   state_d = S_CHK;
      S_CHK: begin
`ifdef DP_SEQ_REPEAT_EN
        if (!N || cnt_q == 4'd0) begin
          state_d = S_DONE;
          flag_d  = N;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          first_d = 1'b0;
          state_d = ((op_q == OP_SHL) || (op_q == OP_SHL1)) ? S_EXEC : S_FETCHA;
        end
`else
        state_d = S_DONE;
        flag_d  = N;
`endif
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Decode controls from the upcoming state so they register in step with it
  always_comb begin
    shl_d    = (op_d == OP_SHL) || (op_d == OP_SHL1);
    ready_d  = (state_d == S_IDLE);
    done_d   = (state_d == S_DONE);
    err_o_d  = done_d & err_d;
    flag_o_d = done_d & flag_d;
    rsel_d   = (state_d == S_EXEC);
    w_d      = (state_d == S_WRIN) || (state_d == S_EXEC);
    loadA_d  = (state_d == S_FETCHA);
    loadN_d  = (state_d == S_EXEC);
    Rw_d     = w_d ? rd_d : '0;
    Rr_d     = '0;
    aluop_d  = '0;
    if (state_d == S_FETCHA) begin
      Rr_d = ra_d;
    end else if (state_d == S_EXEC) begin
      // Later iterations feed the previous result (rd) back as the varying operand
      if (shl_d) Rr_d = first_iter ? ra_d : rd_d;
      else       Rr_d = first_iter ? rb_d : rd_d;
      // Op codes 1..4 map onto aluop 0..3 (the 2-bit subtract wraps 4 to 3)
      aluop_d = op_d[1:0] - 2'd1;
    end
  end

  // State, captured command and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      err_q    <= 1'b0;
      flag_q   <= 1'b0;
`ifdef DP_SEQ_REPEAT_EN
      cnt_q    <= '0;
      first_q  <= 1'b0;
`endif
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_o_q  <= 1'b0;
      flag_o_q <= 1'b0;
      rsel_q   <= 1'b0;
      w_q      <= 1'b0;
      loadA_q  <= 1'b0;
      loadN_q  <= 1'b0;
      Rw_q     <= '0;
      Rr_q     <= '0;
      aluop_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      err_q    <= err_d;
      flag_q   <= flag_d;
`ifdef DP_SEQ_REPEAT_EN
      cnt_q    <= cnt_d;
      first_q  <= first_d;
`endif
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_o_q  <= err_o_d;
      flag_o_q <= flag_o_d;
      rsel_q   <= rsel_d;
      w_q      <= w_d;
      loadA_q  <= loadA_d;
      loadN_q  <= loadN_d;
      Rw_q     <= Rw_d;
      Rr_q     <= Rr_d;
      aluop_q  <= aluop_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign err   = err_o_q;
  assign flag  = flag_o_q;
  assign rsel  = rsel_q;
  assign w     = w_q;
  assign loadA = loadA_q;
  assign loadN = loadN_q;
  assign Rw    = Rw_q;
  assign Rr    = Rr_q;
  assign aluop = aluop_q;

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Multi-cycle controller for the 4-register shift/merge datapath: accepts one command at a time and sequences its control inputs (rsel, w, Rw, Rr, loadA, aluop, loadN) to execute it.
- Sits between a command source (test harness or upper-level FSM) and the datapath; drives no data, only controls.
- Observes the datapath N flag (1 = last ALU result bit 15 clear) and reports it with completion.

Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  command valid; accepted only when ready=1
- op  in  3  command: 000 LOAD, 001 SHL, 010 SHL1, 011 MERGE, 100 SUBHI, 101-111 illegal
- rd  in  2  destination register
- ra  in  2  first source register
- rb  in  2  second source register (MERGE/SUBHI only)
- rpt  in  4  repeat count; used only with the optional feature, ignored otherwise
- ready  out  1  high in IDLE only
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = illegal op
- flag  out  1  valid with done; copy of N after last ALU write, 0 for LOAD/illegal
- rsel, w, loadA, loadN  out  1  datapath controls
- Rw, Rr, aluop  out  2  datapath controls
- N  in  1  datapath flag

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except ready=1; captured command cleared. Reset mid-command aborts it: no further w/loadA/loadN pulses, no done.
- Accept: at a rising edge with start=1 and ready=1, capture op/rd/ra/rb/rpt. start while ready=0 is ignored (not queued).
- States: IDLE, WRIN, FETCHA, EXEC, CHK, DONE.
- Outputs are Moore, decoded from state plus captured fields. Every control not listed for a state is 0.
- IDLE:
  - ready=1.
  - Accept -> LOAD to WRIN; SHL/SHL1 to EXEC; MERGE/SUBHI to FETCHA; illegal to DONE with err latched.
- WRIN:
  - rsel=0, w=1, Rw=rd.
  - The external in bus must be stable during this cycle.
  - Next state DONE.
- FETCHA:
  - Rr=ra, loadA=1.
  - Next state EXEC.
- EXEC:
  - Rr=ra (SHL/SHL1) or rb (MERGE/SUBHI).
  - aluop = 00/01/10/11 for SHL/SHL1/MERGE/SUBHI.
  - rsel=1, w=1, Rw=rd, loadN=1.
  - Next state CHK.
- CHK:
  - No controls asserted; N is now valid.
  - Without the feature, always go to DONE.
- DONE:
  - done=1; err and flag valid.
  - flag is captured from N on the CHK->DONE edge.
  - Next state IDLE.
- Latency, accept edge to done high: LOAD 2 cycles; SHL/SHL1 3; MERGE/SUBHI 4; illegal 1. ready returns the cycle after done.
- Register aliasing (rd equal to ra or rb) is legal. The write occurs at the end of EXEC, after operands are read.

Optional Feature:
- Macro: DP_SEQ_REPEAT_EN.
- Defined: ALU ops execute up to rpt+1 iterations, counted by an internal 4-bit down-counter loaded with rpt at accept.
  - Iteration 1 is as above.
  - Iterations 2 and later read rd in place of ra (SHL/SHL1) or in place of rb (MERGE/SUBHI). MERGE/SUBHI reload A from ra via FETCHA on every iteration.
  - In CHK: if N=0 or counter=0, go to DONE. Otherwise decrement the counter and go to FETCHA (MERGE/SUBHI) or EXEC (SHL/SHL1).
  - LOAD and illegal ops ignore rpt.
- Undefined: rpt is ignored, exactly one iteration, no counter logic.

Test Plan:
- Reset then LOAD: rst_n low mid-EXEC of an SHL -> no w pulse after rst_n falls, ready=1. Then start, op=000, rd=2, in=16'h1234 -> w=1 with Rw=2 one cycle later, done 2 cycles after accept, flag=0, err=0, R2=16'h1234.
- SHL1: R0=16'h0003, op=010, ra=0, rd=1 -> EXEC shows aluop=01, Rr=0, Rw=1; R1=16'h0007, done at +3, flag=1.
- MERGE: R2=16'hAB00, R3=16'h00CD, op=011, ra=2, rb=3, rd=0 -> FETCHA loadA=1 with Rr=2, then EXEC; R0=16'h00CD, done at +4, flag=1.
- SUBHI negative: R1=16'h0100, R2=16'h0005, op=100, ra=1, rb=2, rd=3 -> R3=16'hFFFC, flag=0.
- Illegal and busy: op=111 -> done at +1, err=1, no w/loadA/loadN. A start pulse while ready=0 during an SHL is ignored: exactly one done.
- Repeat (DP_SEQ_REPEAT_EN): R0=16'h0001, op=001, ra=0, rd=0, rpt=3 -> 4 EXEC cycles, R0=16'h0010, done once. Then R0=16'h2000, rpt=5 -> stops after 2 iterations (16'h8000 gives N=0), flag=0.
